// File: rtl/ghost_step.sv
// ghost_step -- grid walker for a maze ghost.
//
// Accepts one-step direction commands, checks the target tile against an
// external wall memory (one-cycle read latency) and moves if it is open.
// After every successful move, and after reset, it probes the four neighbour
// tiles and publishes their open/wall status as clear flags.
//
// Ports
//   clk          sole clock, rising edge
//   resetn       asynchronous active-low reset
//   dir_valid    direction command offered
//   dir          {dx, dy} signed one-step delta
//   dir_ready    command accepted on this edge when high (state IDLE)
//   tile_addr    maze read address {x, y}
//   tile_q       wall bit for the address issued one cycle earlier (1 = wall)
//   location     current position {x, y}
//   clearLeft/Right/Up/Down  neighbour tile is open
//   probe_done   one-cycle pulse when the clear flags were refreshed
//   blocked      one-cycle pulse when an accepted command did not move
module ghost_step #(
  parameter logic [7:0] START_X = 8'd1,
  parameter logic [7:0] START_Y = 8'd1,
  parameter logic [7:0] X_MAX   = 8'd27,
  parameter logic [7:0] Y_MAX   = 8'd30
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        dir_valid,
  input  logic [15:0] dir,
  output logic        dir_ready,
  output logic [15:0] tile_addr,
  input  logic        tile_q,
  output logic [15:0] location,
  output logic        clearLeft,
  output logic        clearRight,
  output logic        clearUp,
  output logic        clearDown,
  output logic        probe_done,
  output logic        blocked
);

  typedef enum logic [2:0] {IDLE, MA, MC, PL, PR, PU, PD, PF} state_t;

  localparam logic [15:0] DIR_LEFT  = 16'hFF00;
  localparam logic [15:0] DIR_RIGHT = 16'h0100;
  localparam logic [15:0] DIR_UP    = 16'h00FF;
  localparam logic [15:0] DIR_DOWN  = 16'h0001;

  localparam logic [7:0]        X_WRAP   = X_MAX + 8'd1;
  localparam logic signed [7:0] STEP_NEG = -8'sd1;
  localparam logic signed [7:0] STEP_POS = 8'sd1;

  // Horizontal tunnel: stepping past X_MAX lands on 0, stepping below 0
  // (which shows up as 8'hFF after the modulo-256 add) lands on X_MAX.
  function automatic logic [7:0] wrap_x(input logic [7:0] x, input logic signed [7:0] dx);
    logic [7:0] s;
    s = x + $unsigned(dx);
    if (s == X_WRAP)
      s = 8'd0;
    else if (s == 8'hFF)
      s = X_MAX;
    return s;
  endfunction

  // Rows have no wrap; anything past Y_MAX (including 8'hFF from 0-1) is
  // treated as solid wall regardless of what the maze memory returns.
  function automatic logic y_in_range(input logic [7:0] y);
    return (y <= Y_MAX);
  endfunction

  state_t      state, state_n;
  logic [7:0]  pos_x, pos_y;
  logic [15:0] dir_r;
  logic        left_p1, right_p1, up_p1;

  logic        dir_legal;
  logic [7:0]  tgt_x, tgt_y;
  logic [7:0]  left_x, right_x, up_y, down_y;
  logic        move_ok;

  assign dir_legal = (dir == DIR_LEFT) || (dir == DIR_RIGHT) ||
                     (dir == DIR_UP)   || (dir == DIR_DOWN);

  // dir_r and position are both stable through MA and MC, so the target is
  // recomputed combinationally in each state instead of being stored.
  assign tgt_x   = wrap_x(pos_x, dir_r[15:8]);
  assign tgt_y   = pos_y + dir_r[7:0];
  assign left_x  = wrap_x(pos_x, STEP_NEG);
  assign right_x = wrap_x(pos_x, STEP_POS);
  assign up_y    = pos_y - 8'd1;
  assign down_y  = pos_y + 8'd1;
  assign move_ok = y_in_range(tgt_y) && !tile_q;

  assign location = {pos_x, pos_y};

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      state <= PL;
    else
      state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (dir_valid && dir_legal) state_n = MA;
      MA:      state_n = MC;
      MC:      state_n = move_ok ? PL : IDLE;
      PL:      state_n = PR;
      PR:      state_n = PU;
      PU:      state_n = PD;
      PD:      state_n = PF;
      PF:      state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output logic: one maze read address per state
  always_comb begin
    dir_ready = (state == IDLE);
    tile_addr = {pos_x, pos_y};
    case (state)
      MA:      tile_addr = {tgt_x, tgt_y};
      PL:      tile_addr = {left_x, pos_y};
      PR:      tile_addr = {right_x, pos_y};
      PU:      tile_addr = {pos_x, up_y};
      PD:      tile_addr = {pos_x, down_y};
      default: tile_addr = {pos_x, pos_y};
    endcase
  end

  // Architectural state: position, published flags and status pulses
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pos_x      <= START_X;
      pos_y      <= START_Y;
      clearLeft  <= 1'b0;
      clearRight <= 1'b0;
      clearUp    <= 1'b0;
      clearDown  <= 1'b0;
      probe_done <= 1'b0;
      blocked    <= 1'b0;
    end else begin
      probe_done <= 1'b0;
      blocked    <= 1'b0;
      case (state)
        IDLE: if (dir_valid && !dir_legal) blocked <= 1'b1;
        MC: begin
          if (move_ok) begin
            pos_x <= tgt_x;
            pos_y <= tgt_y;
          end else begin
            blocked <= 1'b1;
          end
        end
        PF: begin
          clearLeft  <= left_p1;
          clearRight <= right_p1;
          clearUp    <= up_p1;
          clearDown  <= !tile_q && y_in_range(down_y);
          probe_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Probe pipeline: each state captures the result of the read issued in
  // the previous state; values are only consumed after a full PL..PF pass.
  always_ff @(posedge clk) begin
    case (state)
      IDLE:    if (dir_valid) dir_r <= dir;
      PR:      left_p1  <= !tile_q;
      PU:      right_p1 <= !tile_q;
      PD:      up_p1    <= !tile_q && y_in_range(up_y);
      default: ;
    endcase
  end

endmodule
